step_pulse_gen: RTL

//   Turns the raw single-step push button into the clean PCclk step pulse that

---
 rtl/step_pulse_gen.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/step_pulse_gen.sv
// Single-step pulse generator: synchronised, debounced button -> one fixed-width
// PCclk pulse per press, a forced low gap, and a step counter. Auto-run: AUTO_RUN_EN.
module step_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned DB_W            = 20,
    parameter int unsigned PULSE_WIDTH     = 2,
    parameter int unsigned MIN_GAP         = 16,
    parameter int unsigned RUN_DIV         = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_btn,
    input  logic        run_sw,
    output logic        PCclk,
    output logic        busy,
    output logic [15:0] step_count
);

    // One counter serves debounce, pulse and gap timing, so it must fit the largest.
    localparam int unsigned PW_W   = $clog2(PULSE_WIDTH + 1);
    localparam int unsigned GAP_W  = $clog2(MIN_GAP + 1);
    localparam int unsigned PG_W   = (GAP_W > PW_W) ? GAP_W : PW_W;
    localparam int unsigned CNT_W  = (DB_W > PG_W) ? DB_W : PG_W;
    localparam int unsigned TMR_W  = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PW_LAST  = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(MIN_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_PULSE    = 3'd2,
        ST_GAP      = 3'd3,
        ST_RELEASE  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               auto_q, auto_d;
    logic               btn_meta_q, btn_s_q;
    logic               pcclk_q, pcclk_d;
    logic               busy_q, busy_d;
    logic [15:0]        step_count_q, step_count_d;
    logic               run_s;
    logic               fire_s;

    // Button synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
        end else begin
            btn_meta_q <= step_btn;
            btn_s_q    <= btn_meta_q;
        end
    end

`ifdef AUTO_RUN_EN
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RUN_DIV - 1);

    logic             run_meta_q, run_s_q;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    // Run switch synchroniser and auto-step timer
    always_ff @(posedge clk) begin
        if (rst) begin
            run_meta_q <= 1'b0;
            run_s_q    <= 1'b0;
            tmr_q      <= {TMR_W{1'b0}};
        end else begin
            run_meta_q <= run_sw;
            run_s_q    <= run_meta_q;
            tmr_q      <= tmr_d;
        end
    end

    // Timer free-runs only while run is asserted, so the first fire is RUN_DIV after run_s rises
    always_comb begin
        tmr_d = tmr_q;
        if (!run_s_q) begin
            tmr_d = {TMR_W{1'b0}};
        end else if (tmr_q == TMR_LAST) begin
            tmr_d = {TMR_W{1'b0}};
        end else begin
            tmr_d = tmr_q + TMR_W'(1);
        end
    end

    assign run_s  = run_s_q;
    assign fire_s = run_s_q && (tmr_q == TMR_LAST);
`else
    logic             unused_run_s;
    logic [TMR_W-1:0] unused_tmr_s;

    assign unused_run_s = run_sw;
    assign unused_tmr_s = {TMR_W{1'b0}};
    assign run_s        = 1'b0;
    assign fire_s       = 1'b0;
`endif

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            auto_q       <= 1'b0;
            pcclk_q      <= 1'b0;
            busy_q       <= 1'b0;
            step_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            auto_q       <= auto_d;
            pcclk_q      <= pcclk_d;
            busy_q       <= busy_d;
            step_count_q <= step_count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        auto_d  = auto_q;
        case (state_q)
            ST_IDLE: begin
                if (run_s) begin
                    if (fire_s) begin
                        state_d = ST_PULSE;
                        cnt_d   = {CNT_W{1'b0}};
                        auto_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (btn_s_q) begin
                    state_d = ST_DEBOUNCE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DEBOUNCE: begin
                if (run_s || !btn_s_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_PULSE;
                    cnt_d   = {CNT_W{1'b0}};
                    auto_d  = 1'b0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == PW_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = {CNT_W{1'b0}};
                    // An auto fire landing on the last gap cycle must not be lost
                    if (!auto_q) begin
                        state_d = ST_RELEASE;
                    end else if (fire_s) begin
                        state_d = ST_PULSE;
                        auto_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (run_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (btn_s_q) begin
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                auto_d  = 1'b0;
            end
        endcase
    end

    // Outputs follow the next state so PCclk is registered yet aligned with PULSE
    always_comb begin
        pcclk_d      = (state_d == ST_PULSE);
        busy_d       = (state_d == ST_PULSE) || (state_d == ST_GAP);
        step_count_d = step_count_q;
        if ((state_d == ST_PULSE) && (state_q != ST_PULSE)) begin
            step_count_d = step_count_q + 16'd1;
        end else begin
            step_count_d = step_count_q;
        end
    end

    assign PCclk      = pcclk_q;
    assign busy       = busy_q;
    assign step_count = step_count_q;

endmodule
